// File: rtl/nibble_packer.sv
// nibble_packer: gathers a stream of nibbles into WORD_W-bit words, lane 0 in the LSBs,
// with an early close (in_last) that leaves the unused upper lanes at zero.
module nibble_packer #(
  parameter  int NIB_W  = 4,
  parameter  int WORD_W = 128,
  localparam int LANES  = WORD_W / NIB_W,
  localparam int CNT_W  = $clog2(LANES) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [NIB_W-1:0]  in_nib,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic [CNT_W-1:0]  out_count
);
  localparam int IDX_W = $clog2(LANES);
  typedef enum logic {FILL, HOLD} state_t;
  state_t            r_state, w_state_nxt;
  logic [WORD_W-1:0] r_acc, w_merged, r_out_data;
  logic [IDX_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  r_close_cnt, r_out_count, w_cnt_inc;
  logic              r_out_valid;
  logic              w_accept, w_complete, w_slot_free, w_take, w_load, w_xfer;

  assign in_ready    = r_state == FILL;
  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign out_count   = r_out_count;
  assign w_accept    = in_valid && in_ready;
  assign w_complete  = w_accept && (in_last || r_cnt == IDX_W'(LANES - 1));
  assign w_slot_free = !r_out_valid || out_ready;
  assign w_take      = r_out_valid && out_ready;
  assign w_cnt_inc   = CNT_W'(r_cnt) + CNT_W'(1);
  // Lanes at and above r_cnt are always zero, so OR-ing in the nibble is a write.
  assign w_merged    = r_acc | (WORD_W'(in_nib) << (NIB_W * int'(r_cnt)));

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_xfer      = 1'b0;
    if (r_state == FILL) begin
      w_load = w_complete && w_slot_free;
      if (w_complete && !w_slot_free) w_state_nxt = HOLD;
    end else if (out_ready) begin
      w_xfer      = 1'b1;
      w_state_nxt = FILL;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= FILL;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_close_cnt <= '0;
      r_out_data  <= '0;
      r_out_count <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_load || w_xfer) begin
        r_out_data  <= w_load ? w_merged : r_acc;
        r_out_count <= w_load ? w_cnt_inc : r_close_cnt;
        r_out_valid <= 1'b1;
      end else if (w_take) begin
        r_out_valid <= 1'b0;
      end
      if (w_load || w_xfer) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else if (w_accept) begin
        r_acc <= w_merged;
        if (w_complete) r_close_cnt <= w_cnt_inc;
        else            r_cnt <= r_cnt + IDX_W'(1);
      end
    end
  end
endmodule
